// File: rtl/picomips_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : picomips_mc                                                    |
// | Purpose : Multicycle picoMIPS core. FETCH/EXEC state machine with        |
// |           MEM and WAIT_IN states, a synchronous data RAM for LD/ST,      |
// |           and handshaked input/output ports. Program ROM is external     |
// |           and combinational.                                             |
// | Ports   : clk        - clock, rising edge                                |
// |           reset      - synchronous, active-low reset                     |
// |           imem_addr  - program address (the PC)                          |
// |           imem_data  - instruction word from the ROM                     |
// |           in_data    - input port data                                   |
// |           in_valid   - input data available                              |
// |           in_ready   - core accepts input (WAIT_IN only)                 |
// |           outport    - output port register                              |
// |           out_valid  - one-cycle strobe after outport is updated         |
// |           halted     - core is halted                                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
// Assumes Dsize <= n and Psize <= n (addresses are taken from n-bit values).
module picomips_mc #(
  parameter int n      = 8,
  parameter int Psize  = 6,
  parameter int Dsize  = 5,
  parameter int Rcount = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic [Psize-1:0] imem_addr,
  input  logic [n+15:0]    imem_data,
  input  logic [n-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [n-1:0]     outport,
  output logic             out_valid,
  output logic             halted
);

  localparam int RW = $clog2(Rcount);

  localparam logic [5:0] OP_ADD  = 6'h01, OP_ADDI = 6'h02, OP_SUB  = 6'h03,
                         OP_SUBI = 6'h04, OP_AND  = 6'h05, OP_OR   = 6'h06,
                         OP_XOR  = 6'h07, OP_LD   = 6'h08, OP_ST   = 6'h09,
                         OP_IN   = 6'h0A, OP_OUT  = 6'h0B, OP_BEQ  = 6'h0C,
                         OP_BNE  = 6'h0D, OP_JMP  = 6'h0E, OP_HALT = 6'h0F;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_EXEC    = 3'd1,
    S_MEM     = 3'd2,
    S_WAIT_IN = 3'd3,
    S_HALTED  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [Psize-1:0] pc_q, pc_d;
  logic [n+15:0]    ir_q, ir_d;
  logic             z_q, z_d, c_q, c_d;
  logic [n-1:0]     outport_q, outport_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             halted_q, halted_d;

  // Storage without reset: register file and data RAM.
  logic [n-1:0]     rf_q [Rcount];
  logic [n-1:0]     mem_q [2**Dsize];
  logic [n-1:0]     mem_rdata_q;

  logic [5:0]       op;
  logic [4:0]       rd_idx, rs_idx;
  logic [n-1:0]     imm, rd_val, rs_val, alu_b;
  logic [n:0]       sum, diff;
  logic [Dsize-1:0] ea;
  logic [Psize-1:0] pc_inc;
  logic             rd_ok, rs_ok;
  logic             rf_we, mem_we, mem_re;
  logic [n-1:0]     rf_wd;

  assign op     = ir_q[n+15:n+10];
  assign rd_idx = ir_q[n+9:n+5];
  assign rs_idx = ir_q[n+4:n];
  assign imm    = ir_q[n-1:0];

  // Index 0 and indices beyond the implemented file read as zero.
  if (Rcount >= 32) begin : g_full_rf
    assign rd_ok = (rd_idx != 5'd0);
    assign rs_ok = (rs_idx != 5'd0);
  end else begin : g_part_rf
    localparam logic [4:0] RLIM = 5'(Rcount);
    assign rd_ok = (rd_idx != 5'd0) && (rd_idx < RLIM);
    assign rs_ok = (rs_idx != 5'd0) && (rs_idx < RLIM);
  end

  assign rd_val = rd_ok ? rf_q[rd_idx[RW-1:0]] : '0;
  assign rs_val = rs_ok ? rf_q[rs_idx[RW-1:0]] : '0;
  assign alu_b  = (op == OP_ADDI || op == OP_SUBI) ? imm : rs_val;
  assign sum    = {1'b0, rd_val} + {1'b0, alu_b};
  // Bit n of the widened difference is the borrow (rd < operand).
  assign diff   = {1'b0, rd_val} - {1'b0, alu_b};
  assign ea     = Dsize'(rs_val + imm);
  assign pc_inc = pc_q + Psize'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    z_d         = z_q;
    c_d         = c_q;
    outport_d   = outport_q;
    out_valid_d = 1'b0;
    rf_we       = 1'b0;
    rf_wd       = '0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_d    = imem_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (op)
          OP_ADD, OP_ADDI: begin
            rf_we = 1'b1;
            rf_wd = sum[n-1:0];
            z_d   = (sum[n-1:0] == '0);
            c_d   = sum[n];
          end
          OP_SUB, OP_SUBI: begin
            rf_we = 1'b1;
            rf_wd = diff[n-1:0];
            z_d   = (diff[n-1:0] == '0);
            c_d   = diff[n];
          end
          OP_AND: begin rf_we = 1'b1; rf_wd = rd_val & rs_val; end
          OP_OR:  begin rf_we = 1'b1; rf_wd = rd_val | rs_val; end
          OP_XOR: begin rf_we = 1'b1; rf_wd = rd_val ^ rs_val; end
          OP_ST:  mem_we = 1'b1;
          OP_LD: begin
            mem_re  = 1'b1;
            pc_d    = pc_q;
            state_d = S_MEM;
          end
          OP_IN: begin
            pc_d    = pc_q;
            state_d = S_WAIT_IN;
          end
          OP_OUT: begin
            outport_d   = rd_val;
            out_valid_d = 1'b1;
          end
          OP_BEQ: if (z_q)  pc_d = imm[Psize-1:0];
          OP_BNE: if (!z_q) pc_d = imm[Psize-1:0];
          OP_JMP: pc_d = imm[Psize-1:0];
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = S_HALTED;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        rf_we   = 1'b1;
        rf_wd   = mem_rdata_q;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_WAIT_IN: begin
        if (in_valid && in_ready_q) begin
          rf_we   = 1'b1;
          rf_wd   = in_data;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALTED: ;
      default: state_d = S_FETCH;
    endcase
    in_ready_d = (state_d == S_WAIT_IN);
    halted_d   = (state_d == S_HALTED);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      outport_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      z_q         <= z_d;
      c_q         <= c_d;
      outport_q   <= outport_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      halted_q    <= halted_d;
    end
  end

  // Writes are suppressed while reset is low so an aborted instruction
  // leaves no architectural trace.
  always_ff @(posedge clk) begin
    if (reset && rf_we && rd_ok) rf_q[rd_idx[RW-1:0]] <= rf_wd;
  end

  always_ff @(posedge clk) begin
    if (reset && mem_we) mem_q[ea] <= rd_val;
    if (mem_re)          mem_rdata_q <= mem_q[ea];
  end

  assign imem_addr = pc_q;
  assign in_ready  = in_ready_q;
  assign outport   = outport_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_picomips_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_picomips_mc                                                 |
// | Purpose : Directed scoreboard bench for picomips_mc. Each program phase  |
// |           queues its expected OUT words; a monitor pops them whenever    |
// |           out_valid is seen. Control-flow, handshake and reset checks    |
// |           are made directly by the stimulus.                             |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_picomips_mc;

  localparam logic [5:0] NOP = 6'h00, ADD = 6'h01, ADDI = 6'h02, SUB = 6'h03,
                         SUBI = 6'h04, AND_ = 6'h05, LD = 6'h08, ST = 6'h09,
                         IN = 6'h0A, OUT = 6'h0B, BEQ = 6'h0C, BNE = 6'h0D,
                         HALT = 6'h0F;

  typedef struct {
    logic [7:0] data;
    int         cyc;   // expected cycle after reset release, -1 = any
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  imem_addr;
  logic [23:0] imem_data;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  outport;
  logic        out_valid;
  logic        halted;

  logic [23:0] rom [64];
  exp_t        sb_q [$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rel = 0;

  picomips_mc #(.n(8), .Psize(6), .Dsize(5), .Rcount(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .outport   (outport),
    .out_valid (out_valid),
    .halted    (halted)
  );

  assign imem_data = rom[imem_addr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] ins(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = ins(NOP, 0, 0, 0);
  endtask

  task automatic push(input logic [7:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    reset = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1 reset = 1'b1;
    rel = cyc;
  endtask

  task automatic wait_halted(input int budget);
    for (int k = 0; k < budget && !halted; k++) @(negedge clk);
    chk("halt_reached", halted, 1);
  endtask

  task automatic check_frozen(input logic [5:0] addr);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("halted_level", halted, 1);
      chk("halted_pc_frozen", imem_addr, addr);
    end
  endtask

  // Pops one expectation per out_valid strobe.
  task automatic monitor();
    logic prev_ov = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && out_valid === 1'b1) begin
        chk("out_valid_one_cycle", prev_ov, 0);
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: actual=0x%0h required=none", outport);
        end else begin
          e = sb_q.pop_front();
          chk("outport", outport, e.data);
          if (e.cyc >= 0) chk("out_cycle", cyc - rel, e.cyc);
        end
      end
      prev_ov = (reset === 1'b1) && (out_valid === 1'b1);
    end
  endtask

  initial begin
    logic [5:0] seq [$];
    logic [5:0] exp_seq [9];
    int rdy, ph;

    fork
      monitor();
    join_none

    // ---------------- Reset and ALU ----------------
    clear_rom();
    rom[0] = ins(ADDI, 1, 0, 8'h7F);
    rom[1] = ins(ADDI, 1, 1, 8'h01);
    rom[2] = ins(OUT,  1, 0, 8'h00);
    rom[3] = ins(SUBI, 1, 1, 8'h81);
    rom[4] = ins(OUT,  1, 0, 8'h00);
    rom[5] = ins(HALT, 0, 0, 8'h00);
    push(8'h80, 6);
    push(8'hFF, -1);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_outport", outport, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_halted", halted, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    rel = cyc;
    for (int k = 0; k < 20 && (cyc - rel) < 6; k++) @(negedge clk);
    chk("z_after_addi", dut.z_q, 0);
    chk("c_after_addi", dut.c_q, 0);
    wait_halted(40);
    chk("z_after_subi", dut.z_q, 0);
    chk("c_after_subi", dut.c_q, 1);
    check_frozen(6'd5);
    chk("sb_drained_alu", sb_q.size(), 0);

    // ---------------- Load / store ----------------
    clear_rom();
    rom[0] = ins(ADDI, 2, 0, 8'h5A);
    rom[1] = ins(ST,   2, 0, 8'd31);
    rom[2] = ins(LD,   3, 0, 8'd31);
    rom[3] = ins(OUT,  3, 0, 8'h00);
    rom[4] = ins(ADDI, 7, 0, 8'hA5);
    rom[5] = ins(ST,   7, 0, 8'h01);
    rom[6] = ins(AND_, 4, 0, 8'h00);
    rom[7] = ins(LD,   8, 4, 8'h21);
    rom[8] = ins(OUT,  8, 0, 8'h00);
    rom[9] = ins(HALT, 0, 0, 8'h00);
    push(8'h5A, 9);
    push(8'hA5, 20);
    do_reset(2);
    wait_halted(60);
    chk("sb_drained_mem", sb_q.size(), 0);

    // ---------------- Input handshake ----------------
    clear_rom();
    rom[0] = ins(IN,   5, 0, 8'h00);
    rom[1] = ins(OUT,  5, 0, 8'h00);
    rom[2] = ins(IN,   9, 0, 8'h00);
    rom[3] = ins(OUT,  9, 0, 8'h00);
    rom[4] = ins(HALT, 0, 0, 8'h00);
    push(8'h3C, -1);
    push(8'h77, -1);
    in_valid = 1'b0;
    do_reset(2);
    rdy = 0;
    ph  = 0;
    for (int k = 0; k < 60 && !halted; k++) begin
      @(negedge clk);
      if (in_ready) rdy++;
      if (ph == 0 && rdy == 5) begin
        in_valid = 1'b1;
        in_data  = 8'h3C;
        ph = 1;
      end else if (ph == 1 && !in_ready) begin
        chk("pc_after_in", imem_addr, 1);
        in_data = 8'h77;  // left valid so the next IN transfers at once
        ph = 2;
      end
    end
    chk("in_ready_cycles", rdy, 6);
    wait_halted(20);
    in_valid = 1'b0;
    chk("sb_drained_in", sb_q.size(), 0);

    // ---------------- Branch and PC wrap ----------------
    clear_rom();
    rom[0]     = ins(SUB,  6, 6, 8'h00);
    rom[1]     = ins(BEQ,  0, 0, 8'h10);
    rom[2]     = ins(ADDI, 11, 0, 8'hEE);
    rom[3]     = ins(OUT,  11, 0, 8'h00);
    rom[6'h10] = ins(BNE,  0, 0, 8'h20);
    rom[6'h11] = ins(ADDI, 11, 0, 8'h11);
    rom[6'h12] = ins(OUT,  11, 0, 8'h00);
    rom[6'h13] = ins(BNE,  0, 0, 8'h3E);
    rom[6'h3E] = ins(6'h3F, 0, 0, 8'h00);
    rom[6'h3F] = ins(NOP,  0, 0, 8'h00);
    exp_seq = '{6'h00, 6'h01, 6'h10, 6'h11, 6'h12, 6'h13, 6'h3E, 6'h3F, 6'h00};
    push(8'h11, -1);
    do_reset(2);
    seq.delete();
    for (int k = 0; k < 60 && seq.size() < 9; k++) begin
      @(negedge clk);
      if (seq.size() == 0 || imem_addr != seq[$]) seq.push_back(imem_addr);
    end
    chk("pc_seq_len", seq.size(), 9);
    for (int i = 0; i < 9 && i < seq.size(); i++) chk("pc_seq", seq[i], exp_seq[i]);
    chk("sb_drained_br", sb_q.size(), 0);

    // ---------------- Mid-operation reset and HALT ----------------
    clear_rom();
    rom[0] = ins(ADDI, 12, 0, 8'h42);
    rom[1] = ins(IN,   12, 0, 8'h00);
    rom[3] = ins(HALT, 0, 0, 8'h00);
    do_reset(2);
    for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
    chk("in_ready_before_abort", in_ready, 1);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h99;
    @(posedge clk);
    @(negedge clk);
    chk("abort_in_imem_addr", imem_addr, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_in_halted", halted, 0);
    in_valid = 1'b0;
    clear_rom();
    rom[0] = ins(OUT,  12, 0, 8'h00);
    rom[1] = ins(HALT, 0, 0, 8'h00);
    push(8'h42, 2);
    @(posedge clk);
    #1 reset = 1'b1;
    rel = cyc;
    wait_halted(20);
    check_frozen(6'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_halt_imem_addr", imem_addr, 0);
    chk("abort_halt_halted", halted, 0);
    chk("abort_halt_in_ready", in_ready, 0);
    push(8'h42, 2);
    @(posedge clk);
    #1 reset = 1'b1;
    rel = cyc;
    wait_halted(20);
    chk("sb_drained_rst", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
